// File: rtl/pipeline_stage_register.sv
// rtl/pipeline_stage_register.sv - elastic pipeline register with 2-entry skid buffer, flush, NOP bubbles and stall counter
module pipeline_stage_register #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] NOP_VALUE  = 32'h00000013,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [PC_WIDTH-1:0]   pcIn,
  input  logic [DATA_WIDTH-1:0] instIn,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [PC_WIDTH-1:0]   pcOut,
  output logic [DATA_WIDTH-1:0] instOut,
  output logic [CNT_WIDTH-1:0]  stallCount
);

  localparam logic [DATA_WIDTH-1:0] NOP_W   = DATA_WIDTH'(NOP_VALUE);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  logic                  main_valid_q, main_valid_d;
  logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
  logic [DATA_WIDTH-1:0] main_inst_q, main_inst_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  accept, drain;

  // Ready depends only on skid occupancy, so it never has a path from outReady.
  assign inReady    = ~skid_valid_q;
  assign outValid   = main_valid_q;
  assign pcOut      = main_pc_q;
  assign instOut    = main_valid_q ? main_inst_q : NOP_W;
  assign stallCount = stall_cnt_q;

  assign accept = inValid & ~skid_valid_q;
  assign drain  = main_valid_q & outReady;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_pc_d    = skid_pc_q;
        main_inst_d  = skid_inst_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      main_pc_d    = pcIn;
      main_inst_d  = instIn;
      main_valid_d = accept;
    end else if (accept) begin
      skid_pc_d    = pcIn;
      skid_inst_d  = instIn;
      skid_valid_d = 1'b1;
    end
  end

  // Counter is deliberately independent of flush so redirects don't hide stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !outReady && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_inst_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb/tb_pipeline_stage_register.sv - randomized bench for pipeline_stage_register against a queue model
module tb_pipeline_stage_register;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset, flush, inValid, outReady;
  logic [31:0] pcIn, instIn;
  logic        inReady, outValid;
  logic [31:0] pcOut, instOut;
  logic [15:0] stallCount;
  logic        inReady_s, outValid_s;
  logic [31:0] pcOut_s, instOut_s;
  logic [3:0]  stallCount_s;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: a FIFO of at most two entries plus stall counters.
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  int m_cnt = 0;
  int m_cnt_s = 0;
  int acc_count = 0;

  always #5 clock = ~clock;

  pipeline_stage_register dut (
    .clock(clock), .reset(reset), .flush(flush), .inValid(inValid), .inReady(inReady),
    .pcIn(pcIn), .instIn(instIn), .outValid(outValid), .outReady(outReady),
    .pcOut(pcOut), .instOut(instOut), .stallCount(stallCount)
  );

  pipeline_stage_register #(.CNT_WIDTH(4)) dut_sat (
    .clock(clock), .reset(reset), .flush(flush), .inValid(inValid), .inReady(inReady_s),
    .pcIn(pcIn), .instIn(instIn), .outValid(outValid_s), .outReady(outReady),
    .pcOut(pcOut_s), .instOut(instOut_s), .stallCount(stallCount_s)
  );

  task automatic drive(input logic f, input logic v, input logic r,
                       input logic [31:0] pc, input logic [31:0] inst);
    flush = f; inValid = v; outReady = r; pcIn = pc; instIn = inst;
  endtask

  task automatic model_clear();
    q_pc.delete();
    q_inst.delete();
  endtask

  task automatic tick();
    bit had, full, acc, dr;
    @(posedge clock);
    if (reset) begin
      model_clear();
      m_cnt = 0;
      m_cnt_s = 0;
    end else begin
      had = q_pc.size() > 0;
      full = q_pc.size() == 2;
      if (had && !outReady) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      if (flush) model_clear();
      else begin
        acc = inValid && !full;
        dr = had && outReady;
        if (dr) begin void'(q_pc.pop_front()); void'(q_inst.pop_front()); end
        if (acc) begin q_pc.push_back(pcIn); q_inst.push_back(instIn); acc_count++; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL reset_outValid got %0b want 0", outValid); end
    n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL reset_inReady got %0b want 1", inReady); end
    n_vec++; if (pcOut !== 32'h0) begin n_err++; $display("FAIL reset_pcOut got %h want 0", pcOut); end
    n_vec++; if (instOut !== NOP) begin n_err++; $display("FAIL reset_instOut got %h want %h", instOut, NOP); end
    n_vec++; if (stallCount !== 16'h0) begin n_err++; $display("FAIL reset_stallCount got %0d want 0", stallCount); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] inst [3];
    for (int i = 0; i < 3; i++) inst[i] = $urandom;
    n_vec++; if (instOut !== NOP) begin n_err++; $display("FAIL stream_nop_before got %h want %h", instOut, NOP); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'(i * 4), inst[i]);
      tick();
      n_vec++; if (outValid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0b want 1", i, outValid); end
      n_vec++; if (pcOut !== 32'(i * 4)) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, pcOut, 32'(i * 4)); end
      n_vec++; if (instOut !== inst[i]) begin n_err++; $display("FAIL stream_inst[%0d] got %h want %h", i, instOut, inst[i]); end
      n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %0b want 1", i, inReady); end
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL stream_empty got %0b want 0", outValid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ia, ib;
    ia = $urandom; ib = $urandom;
    drive(1'b0, 1'b1, 1'b0, 32'h100, ia);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h104, ib);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    n_vec++; if (inReady !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %0b want 0", inReady); end
    n_vec++; if (pcOut !== 32'h100) begin n_err++; $display("FAIL bp_main_pc got %h want 100", pcOut); end
    n_vec++; if (stallCount !== 16'd2) begin n_err++; $display("FAIL bp_stall got %0d want 2", stallCount); end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    n_vec++; if (pcOut !== 32'h104 || instOut !== ib) begin n_err++; $display("FAIL bp_second got %h/%h want 104/%h", pcOut, instOut, ib); end
    n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %0b want 1", inReady); end
    tick();
    n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %0b want 0", outValid); end
    n_vec++; if (stallCount !== 16'd2) begin n_err++; $display("FAIL bp_stall_final got %0d want 2", stallCount); end
  endtask

  task automatic test_flush();
    logic [31:0] ic;
    ic = $urandom;
    drive(1'b0, 1'b1, 1'b0, 32'h200, $urandom);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h204, $urandom);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h300, $urandom);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h400, ic);
    n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", outValid); end
    n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b want 1", inReady); end
    n_vec++; if (instOut !== NOP) begin n_err++; $display("FAIL flush_nop got %h want %h", instOut, NOP); end
    n_vec++; if (stallCount !== 16'(m_cnt)) begin n_err++; $display("FAIL flush_stall got %0d want %0d", stallCount, m_cnt); end
    tick();
    n_vec++; if (outValid !== 1'b1 || pcOut !== 32'h400 || instOut !== ic) begin
      n_err++; $display("FAIL flush_next got %0b/%h/%h want 1/400/%h", outValid, pcOut, instOut, ic);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] want_inst;
    int target;
    target = acc_count + 100;
    for (int c = 0; c < 2000 && acc_count < target; c++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom, $urandom);
      want_inst = (q_pc.size() > 0) ? q_inst[0] : NOP;
      n_vec++; if (outValid !== (q_pc.size() > 0)) begin n_err++; $display("FAIL rnd_valid got %0b want %0b", outValid, q_pc.size() > 0); end
      n_vec++; if (inReady !== (q_pc.size() < 2)) begin n_err++; $display("FAIL rnd_ready got %0b want %0b", inReady, q_pc.size() < 2); end
      n_vec++; if (instOut !== want_inst) begin n_err++; $display("FAIL rnd_inst got %h want %h", instOut, want_inst); end
      if (q_pc.size() > 0) begin
        n_vec++; if (pcOut !== q_pc[0]) begin n_err++; $display("FAIL rnd_pc got %h want %h", pcOut, q_pc[0]); end
      end
      n_vec++; if (stallCount !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_stall got %0d want %0d", stallCount, m_cnt); end
      n_vec++; if (stallCount_s !== 4'(m_cnt_s)) begin n_err++; $display("FAIL rnd_stall_sat got %0d want %0d", stallCount_s, m_cnt_s); end
      tick();
    end
    n_vec++; if (acc_count < target) begin n_err++; $display("FAIL rnd_timeout got %0d want %0d accepts", acc_count, target); end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick(); tick(); tick();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1, 1'b1, $urandom, $urandom);
      tick();
      n_vec++; if (inReady !== 1'b1 || outValid !== 1'b1) begin n_err++; $display("FAIL thru_flow got %0b/%0b want 1/1", inReady, outValid); end
      n_vec++; if (q_pc.size() != 1 || pcOut !== q_pc[0]) begin n_err++; $display("FAIL thru_pc got %h want %h", pcOut, q_pc[0]); end
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h500, $urandom);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h504, $urandom);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (outValid !== 1'b0 || inReady !== 1'b1) begin n_err++; $display("FAIL arst_flow got %0b/%0b want 0/1", outValid, inReady); end
    n_vec++; if (pcOut !== 32'h0 || instOut !== NOP) begin n_err++; $display("FAIL arst_data got %h/%h want 0/%h", pcOut, instOut, NOP); end
    n_vec++; if (stallCount !== 16'h0) begin n_err++; $display("FAIL arst_stall got %0d want 0", stallCount); end
    model_clear();
    m_cnt = 0;
    m_cnt_s = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] id;
    id = $urandom;
    drive(1'b0, 1'b1, 1'b0, 32'h600, id);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 20; c++) tick();
    n_vec++; if (stallCount_s !== 4'd15) begin n_err++; $display("FAIL sat_count got %0d want 15", stallCount_s); end
    n_vec++; if (stallCount !== 16'd20) begin n_err++; $display("FAIL sat_wide got %0d want 20", stallCount); end
    n_vec++; if (outValid_s !== 1'b1 || inReady_s !== 1'b1 || pcOut_s !== 32'h600 || instOut_s !== id) begin
      n_err++; $display("FAIL sat_entry got %0b/%0b/%h/%h want 1/1/600/%h", outValid_s, inReady_s, pcOut_s, instOut_s, id);
    end
    tick();
    n_vec++; if (stallCount_s !== 4'd15) begin n_err++; $display("FAIL sat_hold got %0d want 15", stallCount_s); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
- Parametrised, elastic pipeline register for inter-stage boundaries of the pipelined RISC-V core; first use is fetch→decode, reusable for decode→execute etc.
- Carries a PC and an instruction/payload word with a valid/ready handshake, a 2-entry skid buffer (full throughput, registered ready), synchronous flush for branch/jump redirect, and NOP injection on bubbles.
- Includes a saturating stall-cycle counter for performance monitoring.

Parameters:
- PC_WIDTH, 32, width of PC field.
- DATA_WIDTH, 32, width of instruction/payload field.
- NOP_VALUE, 32'h00000013, value driven on instOut while outValid=0 (RV32I addi x0,x0,0); truncated/zero-extended to DATA_WIDTH.
- CNT_WIDTH, 16, width of stall counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (redirect).
- inValid  in  1  upstream presents an entry.
- inReady  out  1  stage can accept; registered.
- pcIn  in  PC_WIDTH  upstream PC.
- instIn  in  DATA_WIDTH  upstream instruction.
- outValid  out  1  downstream entry valid.
- outReady  in  1  downstream accepts.
- pcOut  out  PC_WIDTH  held PC.
- instOut  out  DATA_WIDTH  held instruction; NOP_VALUE when outValid=0.
- stallCount  out  CNT_WIDTH  saturating count of back-pressured cycles.

Behaviour:
- Storage: main entry (mainValid, mainPc, mainInst) drives outputs; skid entry (skidValid, skidPc, skidInst) is hidden.
- Reset (async): mainValid=0, skidValid=0, mainPc=0, skidPc=0, inst regs=0, stallCount=0. Outputs: outValid=0, inReady=1, pcOut=0, instOut=NOP_VALUE.
- inReady = !skidValid (direct register output, no combinational path from outReady).
- Accept = inValid & inReady; drain = outValid & outReady.
- outValid = mainValid; pcOut = mainPc; instOut = mainValid ? mainInst : NOP_VALUE.
- Per-cycle update (flush=0), evaluated in order:
  - skidValid=1 and drain: main←skid, skidValid←0 (no accept possible this cycle).
  - skidValid=1 and no drain: hold both.
  - skidValid=0 and (mainValid=0 or drain): main←input, mainValid←Accept.
  - skidValid=0, mainValid=1, no drain, Accept: skid←input, skidValid←1; main holds.
  - Otherwise hold.
- Latency: 1 cycle in→out when empty; sustained throughput 1 entry/cycle with outReady=1.
- Ordering: strict FIFO; no entry duplicated or dropped except by flush.
- Flush: highest priority over all other updates. Next edge: mainValid=0, skidValid=0; the input presented that cycle is dropped even if inValid=1 (inReady may read 1). pcOut and data registers may hold stale values, but instOut reads NOP_VALUE. Entries accepted from the cycle after flush onward are handled normally.
- stallCount: +1 each cycle with outValid=1 & outReady=0, saturating at 2^CNT_WIDTH−1. Not cleared by flush; cleared only by reset.
- Reset mid-operation: immediate (asynchronous) return to reset values; both entries lost.
- Payload widths are independent; no arithmetic on payload.

Test Plan:
- Reset then stream: assert reset, release, push PCs 0x0,0x4,0x8 with outReady=1 → each appears 1 cycle later with outValid=1; inReady stays 1; instOut=NOP_VALUE before the first entry.
- Back-pressure: push 0x100/instr A then 0x104/instr B with outReady=0 → main holds 0x100, skid holds 0x104, inReady=0; raise outReady → 0x100 then 0x104 emerge in order, no loss; stallCount counts exactly the stalled cycles.
- Flush with both entries full plus inValid=1 → next cycle outValid=0, inReady=1, instOut=0x00000013; entry presented in the next cycle emerges normally.
- Simultaneous drain and accept with skid empty → main replaced in the same edge; throughput 1/cycle over 100 random entries matches a reference queue.
- Async reset mid-stall (reset asserted between edges) → outputs return to reset values without waiting for a clock edge; stallCount=0.
- Saturation: CNT_WIDTH=4, hold outValid=1 and outReady=0 for 20 cycles → stallCount=15 and holds.
